// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Watches a multiplexed 4-digit 7-segment scan bus and rebuilds the four
//   displayed digits. Each scan slot (segment pattern plus digit select) has
//   to hold steady for STABLE_CYCLES clocks before it is captured into a
//   shadow frame. Once all four positions have been captured, the shadow
//   frame is committed to the outputs.
//
//   Optional feature macro: SEG7_DEC_CHANGE_EN
//     Defined: keeps the previous committed frame and pulses `changed` when a
//     commit differs from it.
//     Undefined: `changed` is tied low.
//
// Ports
//   clk0        in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   seg7[7:0]   in   segment bus; bit 7 is the decimal point (ignored), 6:0 = g..a
//   line[3:0]   in   one-hot digit select; bit n selects digit n
//   digit0..3   out  committed codes: 0-9, 4'hF blank, 4'hE illegal pattern
//   frame_done  out  one-cycle pulse per committed frame
//   err         out  sticky error flag (illegal pattern or multi-hot select)
//   changed     out  pulses with frame_done when the frame differs from the last one
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 256
) (
  input  logic       clk0,
  input  logic       rst_n,
  input  logic [7:0] seg7,
  input  logic [3:0] line,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       frame_done,
  output logic       err,
  output logic       changed
);

  localparam logic [9:0] CNT_MAX = 10'(STABLE_CYCLES - 1);
  // The capture is tied to the edge on which the counter reaches CNT_MAX,
  // so the condition is checked one count earlier.
  localparam logic [9:0] CNT_PRE = 10'(STABLE_CYCLES - 2);

  logic [6:0]      seg_q;
  logic [3:0]      line_q;
  logic [9:0]      cnt;
  logic            captured;
  logic [3:0]      mask;
  logic [3:0][3:0] shadow;
  logic [3:0][3:0] shown;

  logic       stable, hit, one_hot, multi_hot, cap, commit;
  logic [1:0] idx;
  logic [3:0] code;

  function automatic logic [3:0] dec7(input logic [6:0] s);
    case (s)
      7'h3F:   dec7 = 4'd0;
      7'h06:   dec7 = 4'd1;
      7'h5B:   dec7 = 4'd2;
      7'h4F:   dec7 = 4'd3;
      7'h66:   dec7 = 4'd4;
      7'h6D:   dec7 = 4'd5;
      7'h7D:   dec7 = 4'd6;
      7'h27:   dec7 = 4'd7;
      7'h7F:   dec7 = 4'd8;
      7'h6F:   dec7 = 4'd9;
      7'h00:   dec7 = 4'hF;
      default: dec7 = 4'hE;
    endcase
  endfunction

  always_comb begin
    stable    = (seg7[6:0] == seg_q) && (line == line_q);
    // Counter becomes CNT_MAX on this edge and the slot is not yet captured.
    hit       = stable && (cnt == CNT_PRE) && !captured;
    one_hot   = (line_q != 4'd0) && ((line_q & (line_q - 4'd1)) == 4'd0);
    multi_hot = (line_q != 4'd0) && !one_hot;
    cap       = hit && one_hot;
    idx       = {line_q[3] | line_q[2], line_q[3] | line_q[1]};
    code      = dec7(seg_q);
    commit    = (mask == 4'hF);
  end

  // The input stage samples every cycle, including during reset. A slot that
  // is already steady when reset is released therefore starts counting at the
  // reset edge.
  always_ff @(posedge clk0) begin
    seg_q  <= seg7[6:0];
    line_q <= line;
  end

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      cnt        <= '0;
      captured   <= 1'b0;
      mask       <= '0;
      shadow     <= '1;
      shown      <= '1;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (!stable) begin
        cnt      <= '0;
        captured <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 10'd1;
      end

      // A blank select (line_q == 0) still consumes the slot, but it is legal.
      if (hit)
        captured <= 1'b1;
      if ((hit && multi_hot) || (cap && code == 4'hE))
        err <= 1'b1;

      if (cap)
        shadow[idx] <= code;

      frame_done <= commit;
      if (commit) begin
        // shown takes the pre-edge shadow. A capture on this same edge starts
        // the next frame.
        shown <= shadow;
        mask  <= cap ? (4'd1 << idx) : 4'd0;
      end else if (cap) begin
        mask <= mask | (4'd1 << idx);
      end
    end
  end

  assign digit0 = shown[0];
  assign digit1 = shown[1];
  assign digit2 = shown[2];
  assign digit3 = shown[3];

`ifdef SEG7_DEC_CHANGE_EN
  logic [3:0][3:0] prev_frame;

  always_ff @(posedge clk0) begin
    if (!rst_n) begin
      prev_frame <= '1;
      changed    <= 1'b0;
    end else begin
      changed <= commit && (shadow != prev_frame);
      if (commit)
        prev_frame <= shadow;
    end
  end
`else
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder.
//   The reference model tracks how many consecutive edges the current pin
//   value has been sampled. A slot is taken on the STABLE-th such edge.
//   Frames commit on the edge after all four positions have been seen.
//   The DUT outputs are compared with the model on every falling edge.
//   Directed scenarios add literal expectations on top of the model.
module tb_seg7_scan_decoder;
  localparam int S = 256;

  logic       clk0 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg7 = 8'h00;
  logic [3:0] line = 4'h0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       frame_done, err, changed;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk0(clk0), .rst_n(rst_n), .seg7(seg7), .line(line),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .frame_done(frame_done), .err(err), .changed(changed)
  );

  always #5 clk0 = ~clk0;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%h required=%h at edge-time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27, 7'h7F, 7'h6F};

  function automatic logic [3:0] m_decode(input logic [6:0] s);
    if (s == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++)
      if (pat[i] == s) return 4'(i);
    return 4'hE;
  endfunction

  int         edges = 0;
  int         run = 0;
  logic [10:0] last_pins = '0;
  logic [3:0] m_shadow [4];
  logic [3:0] m_dig [4];
  logic [3:0] m_mask = '0;
  logic       m_fd = 1'b0, m_err = 1'b0, m_chg = 1'b0;

  always @(posedge clk0) begin
    logic [10:0] cur;
    logic        diff;
    edges++;
    cur = {seg7[6:0], line};
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 4'hF;
        m_dig[i]    = 4'hF;
      end
      m_mask = '0; m_fd = 0; m_err = 0; m_chg = 0;
      run = 1;
    end else begin
      run = (cur == last_pins) ? run + 1 : 1;
      m_fd  = (m_mask == 4'hF);
      m_chg = 1'b0;
      if (m_fd) begin
        diff = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (m_dig[i] != m_shadow[i]) diff = 1'b1;
          m_dig[i] = m_shadow[i];
        end
`ifdef SEG7_DEC_CHANGE_EN
        m_chg = diff;
`endif
        m_mask = '0;
      end
      if (run == S) begin
        if ($countones(line) == 1) begin
          for (int i = 0; i < 4; i++)
            if (line[i]) begin
              m_shadow[i] = m_decode(seg7[6:0]);
              m_mask[i]   = 1'b1;
              if (m_shadow[i] == 4'hE) m_err = 1'b1;
            end
        end else if (line != 4'h0) begin
          m_err = 1'b1;
        end
      end
    end
    last_pins = cur;
  end

  // ---------------- compare / monitor ----------------
  int fd_seen = 0, chg_seen = 0, fd_edge = 0;

  always @(negedge clk0) begin
    if (edges > 0) begin
      chk("digit0", digit0, m_dig[0]);
      chk("digit1", digit1, m_dig[1]);
      chk("digit2", digit2, m_dig[2]);
      chk("digit3", digit3, m_dig[3]);
      chk("frame_done", frame_done, m_fd);
      chk("err", err, m_err);
      chk("changed", changed, m_chg);
      if (frame_done === 1'b1) begin
        fd_seen++;
        fd_edge = edges;
      end
      if (changed === 1'b1) chg_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit dp_noise = 0;

  // Holds one slot value for n sampling edges. Every call starts and ends
  // 1 time unit after a rising edge.
  task automatic slot(input logic [3:0] ln, input logic [6:0] sg, input int n);
    line = ln;
    seg7 = {1'b0, sg};
    repeat (n) begin
      @(posedge clk0);
      #1;
      if (dp_noise) seg7[7] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic frame(input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] d);
    slot(4'b0001, a, 300);
    slot(4'b0010, b, 300);
    slot(4'b0100, c, 300);
    slot(4'b1000, d, 300);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, chg0, start;
    int chg_per [3];
    repeat (3) @(posedge clk0);
    #1;
    rst_n = 1'b1;
    @(negedge clk0);
    chk("reset_digit0", digit0, 4'hF);
    chk("reset_digit3", digit3, 4'hF);
    chk("reset_fd", frame_done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_changed", changed, 1'b0);
    @(posedge clk0);
    #1;

    // Basic frame 1,2,3,4 and the commit latency.
    fd0 = fd_seen;
    slot(4'b0001, 7'h06, 300);
    slot(4'b0010, 7'h5B, 300);
    slot(4'b0100, 7'h4F, 300);
    start = edges;
    slot(4'b1000, 7'h66, 300);
    chk("t1_digit0", digit0, 4'd1);
    chk("t1_digit1", digit1, 4'd2);
    chk("t1_digit2", digit2, 4'd3);
    chk("t1_digit3", digit3, 4'd4);
    chk("t1_fd_count", fd_seen - fd0, 1);
    chk("t1_fd_edge", fd_edge - start, 257);
    chk("t1_err", err, 1'b0);

    // A glitch shorter than S clocks is not captured.
    slot(4'b0001, 7'h3F, 300);
    slot(4'b0010, 7'h06, 300);
    slot(4'b0100, 7'h7F, 200);
    slot(4'b0100, 7'h27, 300);
    slot(4'b1000, 7'h4F, 300);
    chk("t2_digit2", digit2, 4'd7);
    chk("t2_digit0", digit0, 4'd0);

    // A blank pattern decodes to F and is not an error.
    frame(7'h00, 7'h06, 7'h5B, 7'h4F);
    chk("t4b_digit0", digit0, 4'hF);
    chk("t4b_err", err, 1'b0);

    // A multi-hot select sets err and captures nothing.
    fd0 = fd_seen;
    slot(4'b0011, 7'h06, 300);
    chk("t3_err_set", err, 1'b1);
    frame(7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("t3_fd_count", fd_seen - fd0, 1);
    chk("t3_digit0", digit0, 4'd1);
    chk("t3_err_sticky", err, 1'b1);

    // An illegal pattern decodes to E.
    frame(7'h55, 7'h5B, 7'h4F, 7'h66);
    chk("t4a_digit0", digit0, 4'hE);
    chk("t4a_err", err, 1'b1);

    // A reset mid-frame discards the partial frame.
    slot(4'b0001, 7'h06, 300);
    slot(4'b0010, 7'h5B, 300);
    pulse_reset();
    fd0 = fd_seen;
    slot(4'b0100, 7'h4F, 300);
    slot(4'b1000, 7'h66, 300);
    chk("t5_fd_none", fd_seen - fd0, 0);
    chk("t5_digit0", digit0, 4'hF);
    chk("t5_digit3", digit3, 4'hF);
    chk("t5_err_cleared", err, 1'b0);

    // Change detection over frames 1234, 1234, 1235.
    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      chg0 = chg_seen;
      frame(7'h06, 7'h5B, 7'h4F, (f == 2) ? 7'h6D : 7'h66);
      chg_per[f] = chg_seen - chg0;
    end
`ifdef SEG7_DEC_CHANGE_EN
    chk("t6_chg_f1", chg_per[0], 1);
    chk("t6_chg_f2", chg_per[1], 0);
    chk("t6_chg_f3", chg_per[2], 1);
`else
    chk("t6_chg_f1", chg_per[0], 0);
    chk("t6_chg_f2", chg_per[1], 0);
    chk("t6_chg_f3", chg_per[2], 0);
`endif
    chk("t6_digit3", digit3, 4'd5);

    // Randomized slots: boundary durations, glitches, odd selects, DP noise.
    dp_noise = 1;
    for (int k = 0; k < 90; k++) begin
      logic [3:0] ln;
      logic [6:0] sg;
      int r, n;
      r = $urandom_range(0, 19);
      if (r < 15) ln = 4'd1 << $urandom_range(0, 3);
      else if (r < 18) ln = 4'h0;
      else ln = 4'(3 << $urandom_range(0, 2));
      sg = ($urandom_range(0, 9) < 7) ? pat[$urandom_range(0, 9)] : 7'($urandom);
      case ($urandom_range(0, 5))
        0: n = $urandom_range(1, S - 1);
        1: n = S - 1;
        2: n = S;
        3: n = S + 1;
        default: n = $urandom_range(S, S + 60);
      endcase
      slot(ln, sg, n);
      if ($urandom_range(0, 24) == 0) pulse_reset();
    end
    dp_noise = 0;
    repeat (4) @(posedge clk0);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Observes a multiplexed 4-digit 7-segment bus (segment pattern plus one-hot digit-select line) and reconstructs the four displayed digits as 4-bit codes. It sits on the receive side of the display scan interface: a board-level loopback checker or self-test monitor feeds it the same `seg7`/`line` nets the display drivers produce. It publishes a coherent 4-digit frame once every digit position has been seen stable.

## Interface
- `STABLE_CYCLES`, 256: consecutive unchanged clocks required before a scan slot is captured; legal range 2..1023.
- `clk0`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `seg7`  input  8  segment bus; bit 7 is the decimal point and is ignored; bits 6:0 are g..a.
- `line`  input  4  digit select; one-hot; bit n selects digit n.
- `digit0`..`digit3`  output  4 each  committed digit codes: 0-9 decoded, 4'hF blank, 4'hE illegal pattern.
- `frame_done`  output  1  one-cycle pulse when a new frame is committed.
- `err`  output  1  sticky error flag.
- `changed`  output  1  frame-change pulse; see Configuration.

## Operation
- Input stage: `seg7[6:0]` and `line` registered into `seg_q`/`line_q` every cycle.
- Stability counter (10 bit): cleared on any edge where pins differ from `seg_q`/`line_q`; otherwise increments, saturating at `STABLE_CYCLES-1`.
- Capture: while counter == `STABLE_CYCLES-1` and not yet captured for this slot and `line_q` is one-hot, decode `seg_q` into `shadow[n]` (n = index of set bit), set `mask[n]`, and set the slot's captured flag. The captured flag clears when the counter clears. One capture per stable slot.
- Decode map (bits 6:0): 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x27→7, 0x7F→8, 0x6F→9, 0x00→F. Any other pattern→E and sets `err`.
- `line_q` = 0 at capture time: no capture, no error, because blank select is legal. `line_q` multi-hot at capture time: no capture, and `err` is set.
- Re-capture of an index already in `mask`: `shadow[n]` is overwritten, latest wins, and `mask` is unchanged.
- Commit: on the edge after `mask` becomes 4'b1111, copy `shadow` to `digit0..3`, pulse `frame_done`, and clear `mask`. A capture on the commit edge is kept and sets its bit in the fresh `mask`.
- Reset (`rst_n` low at an edge, including mid-frame): counter, mask, and captured flag are cleared; `shadow` and `digit0..3` go to 4'hF; `frame_done`, `err`, and `changed` go to 0. Partial frames are discarded.
- `err` is cleared only by reset.

## Timing
- Pins change before edge E0 and then hold. After E0, `_q` holds the new value and the counter is 0.
- Capture happens at edge E0+`STABLE_CYCLES`-1.
- If this completes the mask, `frame_done` is high in the cycle after edge E0+`STABLE_CYCLES`, and `digit*` update on that same edge.
- Glitch rule: a pin change lasting fewer than `STABLE_CYCLES` clocks is never captured.
- `frame_done` is never high on two consecutive cycles. Minimum frame period is 4 slot captures.
- `digit*` change only on commit edges and hold between commits.

## Configuration
- `SEG7_DEC_CHANGE_EN` defined: a register holds the previously committed frame. `changed` pulses together with `frame_done` when any new `digit*` differs from the previous commit. After reset, the previous frame is all 4'hF.
- Not defined: `changed` is tied to 0 and no previous-frame register is built.

## Test plan
- `STABLE_CYCLES`=256. Drive line=0001/seg 0x06, 0010/0x5B, 0100/0x4F, 1000/0x66, each for 300 cycles. Required: `digit0..3`=1,2,3,4; one `frame_done` pulse, 257 edges after the 4th slot starts; `err`=0.
- Hold a digit-2 slot with seg 0x7F for only 200 cycles, then 0x27 for 300 cycles. Required: `digit2`=7, and 8 is never captured.
- Apply line=0011 for 300 cycles. Required: `err`=1 and no mask bit set. Then apply a full valid frame. Required: it commits normally and `err` stays 1.
- Apply seg 0x55 on digit 0 within a full frame. Required: `digit0`=4'hE and `err`=1. Apply seg 0x00 instead. Required: `digit0`=4'hF and `err` stays 0.
- Capture digits 0 and 1, pull `rst_n` low for 1 cycle, then send digits 2 and 3 only. Required: no `frame_done`, and `digit*` stay F.
- With `SEG7_DEC_CHANGE_EN`, send frame 1234 twice then 1235. Required: `changed` pulses on the 1st and 3rd commits only. Without the macro, `changed` stays 0 throughout.
